dmem_responder: RTL and testbench

//  Data-memory responder that services load/store requests issued by the CPU MEM stage.

---
 rtl/dmem_responder_if.sv | 22 ++
 rtl/dmem_responder.sv | 94 +++++++++
 tb/tb_dmem_responder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the CPU MEM stage and the data-memory responder.
interface dmem_responder_if;
   logic        req_re;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        err;

   modport master (
      output req_re, req_we, req_addr, req_wdata, req_be,
      input  stall, rsp_valid, rsp_rdata, err
   );

   modport slave (
      input  req_re, req_we, req_addr, req_wdata, req_be,
      output stall, rsp_valid, rsp_rdata, err
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM for the MEM stage: stores take 1 cycle, loads READ_LAT+2 cycles with a one-cycle rsp_valid.
// Backpressure: stall is held high from load acceptance through the last WAIT cycle; requests are only sampled in IDLE.
module dmem_responder #(
   parameter int ADDR_W   = 16,
   parameter int READ_LAT = 2
) (
   input logic             clk,
   input logic             rst_n,
   dmem_responder_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] req_idx;
   logic [31:0]       rdata_q;
   logic [31:0]       mem [DEPTH];

   logic req_any, req_bad, load_ok, store_ok, rd_en, err_c;

   assign req_idx = bus.req_addr[ADDR_W+1:2];
   assign req_any = bus.req_re | bus.req_we;
   assign req_bad = (bus.req_re & bus.req_we)
                  | (bus.req_addr[1:0] != 2'b00)
                  | (bus.req_addr[31:ADDR_W+2] != '0);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      load_ok  = 1'b0;
      store_ok = 1'b0;
      rd_en    = 1'b0;
      err_c    = 1'b0;
      case (state_q)
         IDLE: begin
            // Gated by rst_n so outputs read zero for the whole reset, not just after the first edge.
            if (rst_n && req_any) begin
               if (req_bad) begin
                  err_c = 1'b1;
               end else if (bus.req_re) begin
                  load_ok = 1'b1;
                  idx_d   = req_idx;
                  cnt_d   = 4'(READ_LAT - 1);
                  state_d = WAIT;
               end else begin
                  store_ok = 1'b1;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               rd_en   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         if (rd_en) rdata_q <= mem[idx_q];
      end
   end

   // RAM has no reset; contents survive rst_n.
   always_ff @(posedge clk) begin
      if (store_ok) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.req_be[b]) mem[req_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
         end
      end
   end

   assign bus.stall     = load_ok | (state_q == WAIT);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.err       = err_c;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized load/store/error traffic against a word-map model.
module tb_dmem_responder;
   localparam int ADDR_W   = 16;
   localparam int READ_LAT = 2;
   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dmem_responder_if bus();

   dmem_responder #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;
   logic [31:0] model [int unsigned];
   logic [31:0] last_rdata;
   int unsigned pool [16];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.req_re    = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;
      bus.req_be    = 4'h0;
   endtask

   function automatic logic [31:0] waddr(input int unsigned w);
      return 32'(w) << 2;
   endfunction

   // All tasks are entered just after a rising edge and return just after one.
   task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      int unsigned w;
      logic [31:0] word;
      bus.req_we = 1'b1; bus.req_re = 1'b0;
      bus.req_addr = addr; bus.req_wdata = data; bus.req_be = be;
      @(negedge clk);
      check("st_err", bus.err, 1'b0);
      check("st_stall", bus.stall, 1'b0);
      check("st_vld", bus.rsp_valid, 1'b0);
      @(posedge clk); #1;
      w = int'(addr >> 2);
      word = model.exists(w) ? model[w] : 32'h0;
      for (int b = 0; b < 4; b++)
         if (be[b]) word[8*b +: 8] = data[8*b +: 8];
      model[w] = word;
      idle_inputs();
   endtask

   task automatic do_load(input logic [31:0] addr);
      logic [31:0] exp;
      exp = model.exists(int'(addr >> 2)) ? model[int'(addr >> 2)] : 32'h0;
      bus.req_re = 1'b1; bus.req_we = 1'b0; bus.req_addr = addr;
      bus.req_wdata = $urandom; bus.req_be = 4'($urandom);
      for (int k = 0; k <= READ_LAT + 1; k++) begin
         @(negedge clk);
         check("ld_stall", bus.stall, (k <= READ_LAT));
         check("ld_vld", bus.rsp_valid, (k == READ_LAT + 1));
         check("ld_err", bus.err, 1'b0);
         if (k == READ_LAT + 1) check("ld_data", bus.rsp_rdata, exp);
         @(posedge clk); #1;
      end
      last_rdata = exp;
      idle_inputs();
   endtask

   task automatic do_err(input logic [31:0] addr, input logic re, input logic we);
      bus.req_re = re; bus.req_we = we; bus.req_addr = addr;
      bus.req_wdata = $urandom; bus.req_be = 4'hF;
      @(negedge clk);
      check("er_err", bus.err, 1'b1);
      check("er_stall", bus.stall, 1'b0);
      check("er_vld", bus.rsp_valid, 1'b0);
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic do_idle();
      @(negedge clk);
      check("id_stall", bus.stall, 1'b0);
      check("id_vld", bus.rsp_valid, 1'b0);
      check("id_err", bus.err, 1'b0);
      check("id_hold", bus.rsp_rdata, last_rdata);
      @(posedge clk); #1;
   endtask

   initial begin
      idle_inputs();
      last_rdata = 32'h0;
      rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("rst_stall", bus.stall, 1'b0);
      check("rst_vld", bus.rsp_valid, 1'b0);
      check("rst_rdata", bus.rsp_rdata, 32'h0);
      check("rst_err", bus.err, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // T1
      do_store(32'h10, 32'hDEADBEEF, 4'hF);
      do_load(32'h10);
      check("t1_data", bus.rsp_rdata, 32'hDEADBEEF);

      // T2
      do_store(32'h20, 32'h11223344, 4'hF);
      do_store(32'h20, 32'h0000AA00, 4'b0010);
      do_load(32'h20);
      check("t2_data", bus.rsp_rdata, 32'h1122AA44);

      // T3
      do_err(32'h22, 1'b1, 1'b0);
      do_err(32'h0004_0000, 1'b1, 1'b0);
      do_idle();

      // T4
      do_store(32'h30, 32'h5, 4'hF);
      do_err(32'h30, 1'b1, 1'b1);
      do_load(32'h30);
      check("t4_data", bus.rsp_rdata, 32'h5);

      // T5: reset lands while the load sits in WAIT
      do_store(32'h40, 32'h12345678, 4'hF);
      bus.req_re = 1'b1; bus.req_addr = 32'h40;
      @(posedge clk); #1;
      @(negedge clk);
      check("t5_stall_pre", bus.stall, 1'b1);
      rst_n = 1'b0;
      idle_inputs();
      #1;
      check("t5_stall", bus.stall, 1'b0);
      check("t5_vld", bus.rsp_valid, 1'b0);
      check("t5_rdata", bus.rsp_rdata, 32'h0);
      check("t5_err", bus.err, 1'b0);
      last_rdata = 32'h0;
      @(posedge clk); @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < READ_LAT + 2; i++) do_idle();
      do_load(32'h40);
      check("t5_data", bus.rsp_rdata, 32'h12345678);

      // T6: top word, then back-to-back loads
      do_store(waddr(DEPTH - 1), 32'hCAFEF00D, 4'hF);
      do_store(32'h0, 32'h0BADC0DE, 4'hF);
      do_load(32'h0003_FFFC);
      do_load(32'h0);
      check("t6_data", bus.rsp_rdata, 32'h0BADC0DE);
      do_err(waddr(DEPTH), 1'b0, 1'b1);

      // Randomized traffic over a small address pool
      pool[0] = 0;
      pool[1] = DEPTH - 1;
      for (int i = 2; i < 16; i++) pool[i] = $urandom_range(DEPTH - 1, 0);
      for (int i = 0; i < 16; i++) do_store(waddr(pool[i]), $urandom, 4'hF);
      for (int n = 0; n < 200; n++) begin
         logic [31:0] a;
         a = waddr(pool[$urandom_range(15, 0)]);
         case ($urandom_range(4, 0))
            0, 1: do_store(a, $urandom, 4'($urandom_range(15, 0)));
            2:    do_load(a);
            3: begin
               case ($urandom_range(2, 0))
                  0: do_err(a, 1'b1, 1'b1);
                  1: do_err(a | 32'($urandom_range(3, 1)), 1'($urandom), 1'b1);
                  default: do_err(a | (32'($urandom_range(255, 1)) << (ADDR_W + 2)), 1'b1, 1'b0);
               endcase
            end
            default: do_idle();
         endcase
      end
      do_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
